fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 149 ++++++++++++++
 tb/tb_fifo_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
`default_nettype none
//============================================================================
// Module      : fifo_reader
// Description : Reads a programmed number of words from a FIFO with a
//               one-cycle read latency and forwards them on a valid/ready
//               stream through a 2-entry skid buffer, marking the final
//               word and pulsing DONE at completion.
// Revision    : 1.0 - initial release
//============================================================================
module fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [CNT_WIDTH-1:0]  LEN,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OUT_LAST,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_req_left;
    logic [CNT_WIDTH-1:0]  r_out_left;
    logic [1:0]            r_occ;
    logic                  r_infl;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_commit;
    logic                  w_rd_en;

    // Occupancy already committed for the cycle after next: what is buffered,
    // plus the word arriving from the previous read, minus the word leaving now.
    assign w_valid  = (r_occ != 2'd0);
    assign w_pop    = w_valid && OUT_READY;
    assign w_commit = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_rd_en  = (r_state == S_RUN) && !EMPTY && (r_req_left != '0)
                      && (w_commit < 3'd2) && !RST;

    assign RD_EN     = w_rd_en;
    assign OUT_DATA  = r_buf0;
    assign OUT_VALID = w_valid;
    assign OUT_LAST  = w_valid && (r_out_left == C_CNT_ONE);
    assign BUSY      = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign DONE      = (r_state == S_FIN);

    // Transfer control: state sequencing plus request and delivery counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_req_left <= '0;
            r_out_left <= '0;
        end else begin
            if (w_rd_en) begin
                r_req_left <= r_req_left - C_CNT_ONE;
            end
            if (w_pop && (r_out_left != '0)) begin
                r_out_left <= r_out_left - C_CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        if (LEN != '0) begin
                            r_state    <= S_RUN;
                            r_req_left <= LEN;
                            r_out_left <= LEN;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en && (r_req_left == C_CNT_ONE)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_pop && (r_out_left == C_CNT_ONE)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Skid buffer: capture the in-flight word at the tail, shift on pop; a
    // simultaneous capture and pop keeps occupancy and preserves order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_infl <= 1'b0;
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_infl <= w_rd_en;
            case ({r_infl, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= RD_DATA;
                    end else begin
                        r_buf1 <= RD_DATA;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= RD_DATA;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= RD_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
//============================================================================
// Module      : tb_fifo_reader
// Description : Directed self-checking bench for fifo_reader. A FIFO model
//               with one-cycle read latency feeds the DUT; a transaction
//               model of the expected word stream, BUSY/DONE phases and
//               stall stability is compared against the DUT every cycle.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fifo_reader;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          CLK;
    logic          RST;
    logic          START;
    logic [CW-1:0] LEN;
    logic          EMPTY;
    logic [DW-1:0] RD_DATA;
    logic          RD_EN;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          OUT_LAST;
    logic          BUSY;
    logic          DONE;

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LEN       (LEN),
        .EMPTY     (EMPTY),
        .RD_DATA   (RD_DATA),
        .RD_EN     (RD_EN),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int   cyc         = 0;
    int   rd_cnt      = 0;
    bit   rd_fire     = 0;
    bit   starve      = 0;
    int   starve_hits = 0;
    int   rdy_mode    = 0;
    int   words_seen  = 0;
    int   done_seen   = 0;
    int   start_cyc   = 0;
    int   first_vcyc  = 0;
    int   done_cyc    = 0;
    bit   fv_pending  = 0;
    int   last_word   = 0;

    // Model state: 0 idle, 1 transfer active, 2 completion cycle.
    int            phase      = 0;
    int            rem        = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record read strobes accepted at each rising edge.
    always @(posedge CLK) begin
        rd_fire = RD_EN;
        if (RD_EN) rd_cnt++;
    end

    // FIFO model: return the popped word during the cycle after the strobe.
    initial begin
        EMPTY   = 1'b1;
        RD_DATA = '0;
        forever begin
            @(negedge CLK);
            if (rd_fire) begin
                if (fifo_q.size() > 0) RD_DATA = fifo_q.pop_front();
                else chk("fifo_underflow", 1, 0);
                rd_fire = 0;
            end
            EMPTY = (starve && (((cyc / 3) % 2) == 1)) || (fifo_q.size() == 0);
        end
    end

    // Compare process: check the DUT against the transaction model each cycle.
    always begin
        int nphase;
        logic [DW-1:0] w;
        @(negedge CLK);
        #1;
        cyc++;
        chk("rd_en_while_empty", int'(RD_EN && EMPTY), 0);
        assert (dut.r_occ <= 2'd2) else chk("occ_bound", int'(dut.r_occ), 2);
        if (RST) begin
            chk("rd_en_in_reset", int'(RD_EN), 0);
            phase = 0; rem = 0; prev_stall = 0; fv_pending = 0;
            exp_q.delete();
        end else begin
            if (starve && EMPTY && BUSY) starve_hits++;
            chk("busy", int'(BUSY), int'(phase == 1));
            chk("done", int'(DONE), int'(phase == 2));
            if (DONE) begin done_seen++; done_cyc = cyc; end
            if (phase != 1) chk("valid_when_idle", int'(OUT_VALID), 0);
            chk("out_last", int'(OUT_LAST), int'(OUT_VALID && phase == 1 && rem == 1));
            if (prev_stall) begin
                chk("stall_valid_held", int'(OUT_VALID), 1);
                chk("stall_data_held", int'(OUT_DATA), int'(prev_data));
            end
            if (OUT_VALID && fv_pending) begin first_vcyc = cyc; fv_pending = 0; end
            nphase = phase;
            if (phase == 2) begin
                nphase = 0;
            end else if (phase == 0 && START) begin
                start_cyc  = cyc;
                fv_pending = 1;
                if (LEN == '0) nphase = 2;
                else begin nphase = 1; rem = int'(LEN); end
            end
            if (OUT_VALID && OUT_READY) begin
                if (phase != 1 || exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_data", int'(OUT_DATA), int'(w));
                    words_seen++;
                    if (OUT_LAST) last_word = int'(OUT_DATA);
                    if (rem == 1) nphase = 2;
                    rem--;
                end
            end
            phase      = nphase;
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
        end
    end

    task automatic tick();
        @(negedge CLK);
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'b0;
            default: OUT_READY = ((cyc % 3) != 2);
        endcase
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
    endtask

    task automatic start_xfer(input int len);
        tick();
        START = 1'b1;
        LEN   = CW'(len);
        tick();
        START = 1'b0;
        LEN   = '0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < budget) begin tick(); n++; end
        chk("done_timeout", int'(done_seen != d0), 1);
        repeat (3) tick();
    endtask

    initial begin
        int r0, w0, d0, n;
        RST = 1'b1; START = 1'b0; LEN = '0; OUT_READY = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_out_last",  int'(OUT_LAST), 0);
        chk("rst_busy",      int'(BUSY), 0);
        chk("rst_done",      int'(DONE), 0);
        chk("rst_out_data",  int'(OUT_DATA), 0);
        RST = 1'b0;
        repeat (2) tick();

        // Streaming: eight words back to back.
        preload(8, 1);
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(8);
        wait_done(100);
        chk("stream_words", words_seen - w0, 8);
        chk("stream_reads", rd_cnt - r0, 8);
        chk("stream_done_once", done_seen - d0, 1);
        chk("stream_first_valid_lat", first_vcyc - start_cyc, 3);
        chk("stream_done_lat", done_cyc - start_cyc, 11);
        chk("stream_last_word", last_word, 16'h0008);

        // Backpressure: sink stalls for 5 cycles after the first valid word.
        preload(4, 16'h0A00);
        rdy_mode = 1;
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(4);
        n = 0;
        while (!OUT_VALID && n < 20) begin tick(); n++; end
        chk("bp_valid_seen", int'(OUT_VALID), 1);
        repeat (5) tick();
        chk("bp_stall_reads_le2", int'((rd_cnt - r0) <= 2), 1);
        rdy_mode = 0;
        wait_done(100);
        chk("bp_words", words_seen - w0, 4);
        chk("bp_reads", rd_cnt - r0, 4);
        chk("bp_done_once", done_seen - d0, 1);
        chk("bp_last_word", last_word, 16'h0A03);

        // Starvation: EMPTY toggles every 3 cycles.
        preload(6, 16'h0C00);
        starve = 1;
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(6);
        wait_done(200);
        starve = 0;
        chk("starve_words", words_seen - w0, 6);
        chk("starve_reads", rd_cnt - r0, 6);
        chk("starve_done_once", done_seen - d0, 1);
        chk("starve_empty_seen", int'(starve_hits > 0), 1);

        // Zero length.
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(0);
        wait_done(10);
        chk("zero_reads", rd_cnt - r0, 0);
        chk("zero_words", words_seen - w0, 0);
        chk("zero_done_once", done_seen - d0, 1);
        chk("zero_done_lat", done_cyc - start_cyc, 1);

        // START pulsed during RUN is ignored.
        preload(5, 16'h0B00);
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(5);
        tick();
        START = 1'b1; LEN = CW'(3);
        tick();
        START = 1'b0; LEN = '0;
        wait_done(100);
        chk("ign_words", words_seen - w0, 5);
        chk("ign_reads", rd_cnt - r0, 5);
        chk("ign_done_once", done_seen - d0, 1);

        // Counter boundary with intermittent ready.
        preload(255, 16'h1000);
        rdy_mode = 2;
        r0 = rd_cnt; w0 = words_seen; d0 = done_seen;
        start_xfer(255);
        wait_done(2000);
        rdy_mode = 0;
        chk("max_words", words_seen - w0, 255);
        chk("max_reads", rd_cnt - r0, 255);
        chk("max_done_once", done_seen - d0, 1);
        chk("max_last_word", last_word, 16'h10FE);

        // Reset after 3 of 8 words.
        preload(8, 16'h2000);
        w0 = words_seen; d0 = done_seen;
        start_xfer(8);
        n = 0;
        while ((words_seen - w0) < 3 && n < 50) begin tick(); n++; end
        chk("rst_mid_reached", words_seen - w0, 3);
        RST = 1'b1;
        tick();
        chk("rst_mid_out_valid", int'(OUT_VALID), 0);
        chk("rst_mid_out_last",  int'(OUT_LAST), 0);
        chk("rst_mid_busy",      int'(BUSY), 0);
        chk("rst_mid_done",      int'(DONE), 0);
        chk("rst_mid_out_data",  int'(OUT_DATA), 0);
        RST = 1'b0;
        repeat (10) tick();
        fifo_q.delete();
        repeat (2) tick();
        chk("rst_mid_words", words_seen - w0, 3);
        chk("rst_mid_no_done", done_seen - d0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
